// File: rtl/sum_sseg_driver.sv
// Multiplexed 4-digit seven-segment driver for a captured adder result (hex),
// with per-slot anti-ghosting blank, optional leading-zero blanking and carry LED.
module sum_sseg_driver #(
    parameter int N           = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK       = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] sum,
    input  logic         c_out,
    input  logic         lzb_en,
    output logic [3:0]   an,
    output logic [6:0]   seg,
    output logic         dp,
    output logic         ovf_led
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [15:0]   value_q, value_d;
    logic          cy_q, cy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          ovf_q;

    logic          wrap;
    logic          slot_blank;
    logic          lz_blank;
    logic [15:0]   shifted;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        value_d = value_q;
        cy_d    = cy_q;
        if (load) begin
            value_d = 16'(sum);
            cy_d    = c_out;
        end

        wrap  = (cnt_q == CW'(REFRESH_DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        sel_d = wrap ? sel_q + 2'd1 : sel_q;

        // The active nibble and everything above it sit in shifted; all-zero means a leading zero.
        shifted    = value_q >> {sel_q, 2'b00};
        lz_blank   = lzb_en && (sel_q != 2'd0) && (shifted == 16'd0);
        slot_blank = (cnt_q < CW'(BLANK));

        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!slot_blank && !lz_blank) begin
            an_d  = ~(4'b0001 << sel_q);
            seg_d = hex7(shifted[3:0]);
            dp_d  = !((sel_q == 2'd0) && cy_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            ovf_q   <= cy_q;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign ovf_led = ovf_q;

endmodule

// File: tb/tb_sum_sseg_driver.sv
// Scoreboard bench for sum_sseg_driver with REFRESH_DIV=4, BLANK=1, N=8:
// each stimulus cycle queues the hand-computed display for the following edge.
module tb_sum_sseg_driver;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] sum;
    logic       c_out;
    logic       lzb_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ovf_led;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mon_idx = 0;

    sum_sseg_driver #(.N(8), .REFRESH_DIV(4), .BLANK(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .sum     (sum),
        .c_out   (c_out),
        .lzb_en  (lzb_en),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .ovf_led (ovf_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_reset(input int tag);
        check("rst_an",  tag, {3'b0, an},      7'h0F);
        check("rst_seg", tag, seg,             7'h7F);
        check("rst_dp",  tag, {6'b0, dp},      7'h01);
        check("rst_ovf", tag, {6'b0, ovf_led}, 7'h00);
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
    task automatic step(input logic ld, input logic [7:0] sm, input logic co,
                        input logic [3:0] ean, input logic [6:0] eseg, input logic edp, input logic eovf);
        load  = ld;
        sum   = sm;
        c_out = co;
        exp_q.push_back('{an: ean, seg: eseg, dp: edp, ovf: eovf});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic slot(input logic [3:0] ean, input logic [6:0] eseg, input logic edp, input logic eovf);
        step(1'b0, 8'h00, 1'b0, 4'hF, 7'h7F, 1'b1, eovf);
        repeat (3) step(1'b0, 8'h00, 1'b0, ean, eseg, edp, eovf);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("an",  mon_idx, {3'b0, an},      {3'b0, e.an});
                check("seg", mon_idx, seg,             e.seg);
                check("dp",  mon_idx, {6'b0, dp},      {6'b0, e.dp});
                check("ovf", mon_idx, {6'b0, ovf_led}, {6'b0, e.ovf});
                mon_idx++;
            end
        end
    end

    initial begin : stimulus
        rst = 1'b0; load = 1'b0; sum = 8'h00; c_out = 1'b0; lzb_en = 1'b0;
        #2 rst = 1'b1;
        #10 check_reset(0);
        @(negedge clk);
        rst = 1'b0;

        // No load: value 0 shown on every digit, slot sequence 0..3.
        slot(4'hE, 7'h40, 1'b1, 1'b0);
        slot(4'hD, 7'h40, 1'b1, 1'b0);
        slot(4'hB, 7'h40, 1'b1, 1'b0);
        slot(4'h7, 7'h40, 1'b1, 1'b0);

        // A5 with carry, no blanking.
        step(1'b1, 8'hA5, 1'b1, 4'hF, 7'h7F, 1'b1, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 4'hE, 7'h12, 1'b0, 1'b1);
        slot(4'hD, 7'h08, 1'b1, 1'b1);
        slot(4'hB, 7'h40, 1'b1, 1'b1);
        slot(4'h7, 7'h40, 1'b1, 1'b1);

        // 05 with leading-zero blanking.
        lzb_en = 1'b1;
        step(1'b1, 8'h05, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0, 4'hE, 7'h12, 1'b1, 1'b0);
        repeat (3) slot(4'hF, 7'h7F, 1'b1, 1'b0);

        // 00 with blanking: digit 0 still lit.
        step(1'b1, 8'h00, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 4'hE, 7'h40, 1'b1, 1'b0);
        repeat (3) slot(4'hF, 7'h7F, 1'b1, 1'b0);

        // 30 with carry and blanking: zero digit 0 kept, digit 1 shown, 2/3 blanked.
        step(1'b1, 8'h30, 1'b1, 4'hF, 7'h7F, 1'b1, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 4'hE, 7'h40, 1'b0, 1'b1);
        slot(4'hD, 7'h30, 1'b1, 1'b1);
        slot(4'hF, 7'h7F, 1'b1, 1'b1);
        slot(4'hF, 7'h7F, 1'b1, 1'b1);

        // Load 7C on the wrap edge of the digit-0 slot.
        lzb_en = 1'b0;
        step(1'b0, 8'h00, 1'b0, 4'hF, 7'h7F, 1'b1, 1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b0, 4'hE, 7'h40, 1'b0, 1'b1);
        step(1'b1, 8'h7C, 1'b0, 4'hE, 7'h40, 1'b0, 1'b1);
        slot(4'hD, 7'h78, 1'b1, 1'b0);
        slot(4'hB, 7'h40, 1'b1, 1'b0);
        slot(4'h7, 7'h40, 1'b1, 1'b0);
        slot(4'hE, 7'h46, 1'b1, 1'b0);

        // Load FF, then asynchronous reset mid-slot while load is still asserted.
        step(1'b1, 8'hFF, 1'b1, 4'hF, 7'h7F, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 4'hD, 7'h0E, 1'b1, 1'b1);
        #2;
        rst   = 1'b1;
        load  = 1'b1;
        sum   = 8'hFF;
        c_out = 1'b1;
        #1 check_reset(1);
        repeat (2) @(negedge clk);
        check_reset(2);
        rst = 1'b0;
        slot(4'hE, 7'h40, 1'b1, 1'b0);
        slot(4'hD, 7'h40, 1'b1, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sum_sseg_driver.md
SUM_SSEG_DRIVER -- requirements
Module: sum_sseg_driver

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the adder sum width; legal range 1..16.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000, giving clock cycles per digit slot; legal minimum 4.
REQ-003 The block SHALL have parameter BLANK, default 16, giving the all-off cycles at the start of each slot; legal range 1..REFRESH_DIV-2.
REQ-004 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port load, input, 1 bit: capture strobe for sum and c_out.
REQ-007 Port sum, input, N bits: adder sum result.
REQ-008 Port c_out, input, 1 bit: adder carry-out.
REQ-009 Port lzb_en, input, 1 bit: leading-zero blanking enable, sampled every cycle.
REQ-010 Port an, output, 4 bits: digit anodes, active-low; bit k selects hex digit k, with k=0 least significant.
REQ-011 Port seg, output, 7 bits: segment cathodes {g,f,e,d,c,b,a}, active-low.
REQ-012 Port dp, output, 1 bit: decimal point, active-low.
REQ-013 Port ovf_led, output, 1 bit: captured carry-out, active-high.

Function
REQ-014 When load=1 at a rising edge, the block SHALL capture sum, zero-extended to 16 bits, into value, and c_out into cy; otherwise value and cy SHALL hold.
REQ-015 Refresh counter cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; on wrap, digit_sel SHALL advance (0,1,2,3,0...).
REQ-016 Load SHALL NOT reset or disturb cnt or digit_sel.
REQ-017 an, seg and dp SHALL be registered; at each edge they SHALL be computed from the pre-edge cnt, digit_sel, value, cy and lzb_en (one-cycle lag).
REQ-018 When cnt < BLANK, outputs SHALL be an=4'b1111, seg=7'h7F, dp=1 (anti-ghosting).
REQ-019 Otherwise, an SHALL drive only bit digit_sel low, and seg SHALL show hex nibble value[4*digit_sel+3 : 4*digit_sel].
REQ-020 Hex encoding (active-low {g..a}) SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-021 With lzb_en=1, digit k (k>=1) SHALL be blanked (an all 1, seg=7F) when nibble k and all higher nibbles are zero; digit 0 SHALL never be blanked.
REQ-022 dp SHALL be 0 only during a non-blank digit-0 slot with cy=1; otherwise dp SHALL be 1.
REQ-023 ovf_led SHALL equal cy, registered.
REQ-024 A value captured at edge t SHALL appear on seg no earlier than edge t+1, and only while the matching digit is active.
REQ-025 Simultaneous load and cnt wrap SHALL both take effect at the same edge.

Reset
REQ-026 While rst=1, regardless of clk, the block SHALL hold: value=0, cy=0, cnt=0, digit_sel=0, an=4'b1111, seg=7'h7F, dp=1, ovf_led=0.
REQ-027 After rst falls, the first slot SHALL be digit 0 starting at cnt=0.
REQ-028 Reset asserted mid-slot or mid-load SHALL discard the captured value.

Verification (REFRESH_DIV=4, BLANK=1, N=8)
REQ-029 Reset release, no load -> an cycles 1111,1110,1110,1110,1111,1101,...; seg=40 in every active slot; dp=1; ovf_led=0.
REQ-030 load with sum=8'hA5, c_out=1, lzb_en=0 -> digit0 seg=12 and dp=0; digit1 seg=08; digits 2,3 seg=40; ovf_led=1 one edge after capture.
REQ-031 load with sum=8'h05, lzb_en=1 -> digits 1..3 fully blank (an=1111); digit0 seg=12.
REQ-032 load with sum=8'h00, lzb_en=1 -> only digit0 lit with seg=40.
REQ-033 load pulsed on the wrap edge -> new value is shown on the next active slot; digit sequence is not disturbed.
REQ-034 rst pulsed mid-slot after loading 8'hFF -> outputs go to reset values immediately, without a clock edge; after release, digit0 slot shows seg=40.
